uart_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the UART receive path of the RSA datapath.
//  - Consumes the one-cycle rx_valid/rx_byte strobes from the UART receiver.
//  - Validates a framed command: SYNC, OPCODE, LEN, payload, CHECKSUM.
//  - Packs payload bytes into 16-bit words, MSB byte first.
//  - Writes the words into the operand RAM at consecutive addresses.
//  - Flags frame_done or frame_err so the RSA core starts only on clean operands.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_frame_ctrl_if.sv | 31 +++
 rtl/rx_timeout_ctr.sv | 32 +++
 rtl/uart_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame sequencer.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPC  = 3'd1,
    S_LEN  = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4,
    S_CSUM = 3'd5
  } state_t;

  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-in / word-out bundle between the UART receiver, the frame sequencer
// and the operand RAM. master = the sequencer, slave = its environment.
interface uart_frame_ctrl_if #(
  parameter int ADDR_W = 6
) ();

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [7:0]        frame_opcode;
  logic [ADDR_W:0]   frame_len;
  logic              frame_done;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    input  rx_valid, rx_byte,
    output wr_en, wr_addr, wr_data, frame_opcode, frame_len,
           frame_done, frame_err, err_code, busy
  );

  modport slave (
    output rx_valid, rx_byte,
    input  wr_en, wr_addr, wr_data, frame_opcode, frame_len,
           frame_done, frame_err, err_code, busy
  );

endinterface

// File: rtl/rx_timeout_ctr.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// flags the cycle on which TIMEOUT_CYC-1 has been reached.
module rx_timeout_ctr #(
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  assign expired_o = enable_i && (cnt_q == LAST);

  // Count idle cycles; wrap to zero on expiry so the count never overruns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame-level sequencer for the UART receive path: checks SYNC/OPCODE/LEN/
// payload/CHECKSUM framing, packs payload into 16-bit words (MSB first) and
// writes them to the operand RAM, then pulses frame_done or frame_err.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int MAX_WORDS   = 64,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic             iCE_CLK,
  input  logic             rst,
  uart_frame_ctrl_if.master fr
);

  localparam int         IW      = ADDR_W + 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [7:0]        csum_q;
  logic [7:0]        csum_d;
  logic [7:0]        hi_q;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic [7:0]        opcode_q;
  logic [IW-1:0]     len_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic              busy_q;

  logic              tmo_expired;

  assign idx_d  = idx_q + IW'(1);
  assign csum_d = csum_q ^ fr.rx_byte;

  // The timer only runs inside a frame and restarts on every received byte.
  rx_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk       (iCE_CLK),
    .rst       (rst),
    .clear_i   (fr.rx_valid || (state_q == S_IDLE)),
    .enable_i  (state_q != S_IDLE),
    .expired_o (tmo_expired)
  );

  // Frame FSM with registered outputs; a received byte always beats a timeout.
  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      hi_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      opcode_q   <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (fr.rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (fr.rx_byte == SYNC_BYTE) begin
              state_q <= S_OPC;
              busy_q  <= 1'b1;
            end
          end
          S_OPC: begin
            opcode_q <= fr.rx_byte;
            csum_q   <= fr.rx_byte;
            state_q  <= S_LEN;
          end
          S_LEN: begin
            if ((fr.rx_byte == 8'd0) || (fr.rx_byte > MAX_LEN)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
            end else begin
              len_q   <= IW'(fr.rx_byte);
              csum_q  <= csum_d;
              idx_q   <= '0;
              state_q <= S_HI;
            end
          end
          S_HI: begin
            hi_q    <= fr.rx_byte;
            csum_q  <= csum_d;
            state_q <= S_LO;
          end
          S_LO: begin
            wr_data_q <= {hi_q, fr.rx_byte};
            wr_addr_q <= idx_q[ADDR_W-1:0];
            wr_en_q   <= 1'b1;
            csum_q    <= csum_d;
            idx_q     <= idx_d;
            state_q   <= (idx_d == len_q) ? S_CSUM : S_HI;
          end
          S_CSUM: begin
            if (fr.rx_byte == csum_q) begin
              done_q <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (tmo_expired) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TMO;
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
      end
    end
  end

  assign fr.wr_en        = wr_en_q;
  assign fr.wr_addr      = wr_addr_q;
  assign fr.wr_data      = wr_data_q;
  assign fr.frame_opcode = opcode_q;
  assign fr.frame_len    = len_q;
  assign fr.frame_done   = done_q;
  assign fr.frame_err    = err_q;
  assign fr.err_code     = err_code_q;
  assign fr.busy         = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: table of frames plus hand-written timeout and
// reset sequences, with write/event scoreboards checked every cycle.
module tb_uart_frame_ctrl;
  import uart_frame_pkg::*;

  localparam int AW   = 6;
  localparam int MAXW = 64;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_ctrl_if #(.ADDR_W(AW)) fr ();

  uart_frame_ctrl #(
    .MAX_WORDS   (MAXW),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .iCE_CLK (clk),
    .rst     (rst),
    .fr      (fr.master)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    int         junk;
    logic [7:0] opc;
    logic [7:0] len;
    logic [15:0] seed;
    logic [15:0] step;
    logic [7:0] cx;
    int         gap;
    logic [1:0] exp_code;
  } vec_t;

  wr_t  exp_wr[$];
  ev_t  exp_ev[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [AW:0] last_len = '0;
  logic [7:0]  junkb [3];
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({fr.wr_en, fr.wr_addr, fr.wr_data, fr.frame_opcode, fr.frame_len,
                fr.frame_done, fr.frame_err, fr.err_code, fr.busy});
  endfunction

  // One clock; sample #1 after the edge and settle scoreboards.
  task automatic tick();
    wr_t w;
    ev_t e;
    @(posedge clk);
    #1;
    if (fr.wr_en) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: got write %0h@%0h, required none", fr.wr_data, fr.wr_addr);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(fr.wr_addr), 64'(w.addr));
        chk("wr_data", 64'(fr.wr_data), 64'(w.data));
      end
    end
    if (fr.frame_done || fr.frame_err) begin
      if (exp_ev.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ev_unexpected: got done=%0b err=%0b code=%0d, required none",
                 fr.frame_done, fr.frame_err, fr.err_code);
      end else begin
        e = exp_ev.pop_front();
        chk("ev_kind", 64'({fr.frame_err, fr.frame_done}), e.is_err ? 64'd2 : 64'd1);
        if (e.is_err) chk("err_code", 64'(fr.err_code), 64'(e.code));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    fr.rx_valid = 1'b1;
    fr.rx_byte  = b;
    tick();
    fr.rx_valid = 1'b0;
    fr.rx_byte  = 8'h00;
  endtask

  task automatic push_ev(input logic is_err, input logic [1:0] code);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    exp_ev.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0]  cs;
    logic [15:0] w;
    logic        len_bad;
    len_bad = (v.len == 8'd0) || (v.len > 8'(MAXW));
    for (int j = 0; j < v.junk; j++) begin
      send_byte(junkb[j % 3]);
      repeat (v.gap) tick();
    end
    send_byte(SYNC_BYTE);
    repeat (v.gap) tick();
    send_byte(v.opc);
    chk($sformatf("v%0d_busy_mid", id), 64'(fr.busy), 64'd1);
    repeat (v.gap) tick();
    cs = v.opc;
    if (len_bad) begin
      push_ev(1'b1, v.exp_code);
      send_byte(v.len);
      chk($sformatf("v%0d_len_latency", id), 64'(exp_ev.size()), 64'd0);
    end else begin
      cs = cs ^ v.len;
      send_byte(v.len);
      for (int i = 0; i < int'(v.len); i++) begin
        repeat (v.gap) tick();
        w  = v.seed + 16'(i) * v.step;
        cs = cs ^ w[15:8] ^ w[7:0];
        send_byte(w[15:8]);
        repeat (v.gap) tick();
        push_wr(AW'(i), w);
        send_byte(w[7:0]);
      end
      repeat (v.gap) tick();
      push_ev(v.exp_code != 2'd0, v.exp_code);
      send_byte(cs ^ v.cx);
      chk($sformatf("v%0d_end_latency", id), 64'(exp_ev.size()), 64'd0);
      last_len = v.len[AW:0];
    end
    repeat (2) tick();
    chk($sformatf("v%0d_wr_drain", id), 64'(exp_wr.size()), 64'd0);
    chk($sformatf("v%0d_busy_after", id), 64'(fr.busy), 64'd0);
    chk($sformatf("v%0d_opcode", id), 64'(fr.frame_opcode), 64'(v.opc));
    chk($sformatf("v%0d_len", id), 64'(fr.frame_len), 64'(last_len));
    if (v.exp_code != 2'd0)
      chk($sformatf("v%0d_code_held", id), 64'(fr.err_code), 64'(v.exp_code));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    junkb = '{8'h00, 8'hFF, 8'h3C};
    vecs[0] = '{0, 8'h10, 8'd2,  16'h1234, 16'h4444, 8'h00, 0, 2'd0};
    vecs[1] = '{0, 8'h10, 8'd2,  16'h1234, 16'h4444, 8'h41, 1, ERR_CSUM};
    vecs[2] = '{0, 8'h20, 8'd0,  16'h0000, 16'h0000, 8'h00, 0, ERR_LEN};
    vecs[3] = '{1, 8'h21, 8'd65, 16'h0000, 16'h0000, 8'h00, 0, ERR_LEN};
    vecs[4] = '{3, 8'h22, 8'd3,  16'hA5A5, 16'h0101, 8'h00, 0, 2'd0};
    vecs[5] = '{0, 8'h7E, 8'd64, 16'h0000, 16'h0103, 8'h00, 0, 2'd0};
    vecs[6] = '{2, 8'hA5, 8'd1,  16'h00A5, 16'h0000, 8'h00, 2, 2'd0};
    vecs[7] = '{0, 8'h33, 8'd5,  16'hFFFF, 16'h1111, 8'hFF, 3, ERR_CSUM};

    fr.rx_valid = 1'b0;
    fr.rx_byte  = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Timeout after the HI byte.
    send_byte(SYNC_BYTE);
    send_byte(8'h44);
    send_byte(8'h02);
    send_byte(8'hAB);
    push_ev(1'b1, ERR_TMO);
    repeat (TMO - 1) tick();
    chk("tmo_not_early", 64'(exp_ev.size()), 64'd1);
    tick();
    chk("tmo_fired", 64'(exp_ev.size()), 64'd0);
    chk("tmo_busy", 64'(fr.busy), 64'd0);
    chk("tmo_code", 64'(fr.err_code), 64'(ERR_TMO));
    repeat (2) tick();

    // Byte on the expiry cycle keeps the frame alive.
    cs = 8'h44 ^ 8'h02;
    send_byte(SYNC_BYTE);
    send_byte(8'h44);
    send_byte(8'h02);
    send_byte(8'hAB);
    repeat (TMO - 1) tick();
    push_wr(AW'(0), 16'hABCD);
    send_byte(8'hCD);
    chk("expiry_busy", 64'(fr.busy), 64'd1);
    repeat (TMO - 2) tick();
    send_byte(8'h12);
    push_wr(AW'(1), 16'h1234);
    send_byte(8'h34);
    cs = cs ^ 8'hAB ^ 8'hCD ^ 8'h12 ^ 8'h34;
    push_ev(1'b0, 2'd0);
    send_byte(cs);
    chk("expiry_done_latency", 64'(exp_ev.size()), 64'd0);
    repeat (2) tick();
    chk("expiry_wr_drain", 64'(exp_wr.size()), 64'd0);

    // Reset mid-frame discards the frame without a pulse.
    send_byte(SYNC_BYTE);
    send_byte(8'h10);
    send_byte(8'h03);
    send_byte(8'h11);
    push_wr(AW'(0), 16'h1122);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 64'd0);
    tick();
    chk("rst_hold_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    last_len = '0;
    chk("rst_queues", 64'(exp_wr.size() + exp_ev.size()), 64'd0);
    tick();
    run_vec('{0, 8'h55, 8'd2, 16'hBEEF, 16'h0001, 8'h00, 0, 2'd0}, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
